// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter driving open-collector pull-low enables.
// Define PS2_TX_RETRY_EN to retry a NACKed or timed-out byte up to two more times.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 12000,
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code
);

  localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned FLT_W = $clog2(FILTER_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SEND,
    S_ACK,
    S_WAIT_IDLE
  } state_e;

  logic             clk_meta_q, clk_meta_d;
  logic             clk_sync_q, clk_sync_d;
  logic             data_meta_q, data_meta_d;
  logic             data_sync_q, data_sync_d;
  logic             clk_flt_q, clk_flt_d;
  logic [FLT_W-1:0] flt_cnt_q, flt_cnt_d;
  logic             fall_q, fall_d;

  state_e           state_q, state_d;
  logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [3:0]       bit_idx_q, bit_idx_d;
  logic [10:0]      shift_q, shift_d;
  logic             nack_q, nack_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [1:0]       err_code_q, err_code_d;
`ifdef PS2_TX_RETRY_EN
  logic [1:0]       retry_q, retry_d;
`endif

  logic             to_hit;
  logic             fin;
  logic [1:0]       fin_code;
  logic             retry_now;

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign err_code    = err_code_q;

  always_comb begin
    clk_meta_d  = ps2_clk_in;
    clk_sync_d  = clk_meta_q;
    data_meta_d = ps2_data_in;
    data_sync_d = data_meta_q;
  end

  // The filtered clock only follows after FILTER_LEN disagreeing samples in a row.
  always_comb begin
    flt_cnt_d = '0;
    clk_flt_d = clk_flt_q;
    if (clk_sync_q != clk_flt_q) begin
      if (flt_cnt_q == FLT_W'(FILTER_LEN - 1)) begin
        clk_flt_d = clk_sync_q;
      end else begin
        flt_cnt_d = flt_cnt_q + 1'b1;
      end
    end
    fall_d = clk_flt_q & ~clk_flt_d;
  end

  assign to_hit = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d    = state_q;
    inh_cnt_d  = inh_cnt_q;
    to_cnt_d   = to_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    nack_d     = nack_q;
    clk_oe_d   = 1'b0;
    data_oe_d  = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_code_d = 2'd0;
    fin        = 1'b0;
    fin_code   = 2'd0;
    retry_now  = 1'b0;
`ifdef PS2_TX_RETRY_EN
    retry_d    = retry_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (tx_start && !done_q) begin
          state_d   = S_INHIBIT;
          inh_cnt_d = '0;
          shift_d   = {1'b1, ~^tx_data, tx_data, 1'b0};
          busy_d    = 1'b1;
          clk_oe_d  = 1'b1;
`ifdef PS2_TX_RETRY_EN
          retry_d   = 2'd0;
`endif
        end
      end

      // Start bit overlaps the last inhibit cycle before clock release.
      S_INHIBIT: begin
        clk_oe_d = 1'b1;
        if (inh_cnt_q == INH_W'(INHIBIT_CYCLES)) begin
          state_d   = S_REQ;
          to_cnt_d  = '0;
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
        end else begin
          inh_cnt_d = inh_cnt_q + 1'b1;
          data_oe_d = (inh_cnt_q == INH_W'(INHIBIT_CYCLES - 1));
        end
      end

      S_REQ: begin
        data_oe_d = 1'b1;
        if (fall_q) begin
          state_d   = S_SEND;
          bit_idx_d = 4'd1;
          data_oe_d = ~shift_q[1];
          to_cnt_d  = '0;
        end else if (to_hit) begin
          fin      = 1'b1;
          fin_code = 2'd2;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

      S_SEND: begin
        data_oe_d = ~shift_q[bit_idx_q];
        if (fall_q) begin
          to_cnt_d = '0;
          if (bit_idx_q == 4'd10) begin
            state_d   = S_ACK;
            nack_d    = data_sync_q;
            data_oe_d = 1'b0;
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
            data_oe_d = ~shift_q[bit_idx_d];
          end
        end else if (to_hit) begin
          fin      = 1'b1;
          fin_code = 2'd2;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

      S_ACK: begin
        state_d  = S_WAIT_IDLE;
        to_cnt_d = '0;
      end

      S_WAIT_IDLE: begin
        if (to_hit) begin
          fin      = 1'b1;
          fin_code = 2'd2;
        end else if (clk_flt_q && data_sync_q) begin
          fin      = 1'b1;
          fin_code = nack_q ? 2'd1 : 2'd0;
        end else begin
          to_cnt_d = fall_q ? '0 : to_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifdef PS2_TX_RETRY_EN
    retry_now = fin && (fin_code != 2'd0) && (retry_q != 2'd2);
`endif

    if (retry_now) begin
      state_d   = S_INHIBIT;
      inh_cnt_d = '0;
      to_cnt_d  = '0;
      clk_oe_d  = 1'b1;
      data_oe_d = 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_d   = retry_q + 2'd1;
`endif
    end else if (fin) begin
      state_d    = S_IDLE;
      to_cnt_d   = '0;
      clk_oe_d   = 1'b0;
      data_oe_d  = 1'b0;
      busy_d     = 1'b0;
      done_d     = 1'b1;
      err_d      = (fin_code != 2'd0);
      err_code_d = fin_code;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
      clk_flt_q   <= 1'b1;
      flt_cnt_q   <= '0;
      fall_q      <= 1'b0;
      state_q     <= S_IDLE;
      inh_cnt_q   <= '0;
      to_cnt_q    <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      nack_q      <= 1'b0;
      clk_oe_q    <= 1'b0;
      data_oe_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= 2'd0;
`ifdef PS2_TX_RETRY_EN
      retry_q     <= 2'd0;
`endif
    end else begin
      clk_meta_q  <= clk_meta_d;
      clk_sync_q  <= clk_sync_d;
      data_meta_q <= data_meta_d;
      data_sync_q <= data_sync_d;
      clk_flt_q   <= clk_flt_d;
      flt_cnt_q   <= flt_cnt_d;
      fall_q      <= fall_d;
      state_q     <= state_d;
      inh_cnt_q   <= inh_cnt_d;
      to_cnt_q    <= to_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      nack_q      <= nack_d;
      clk_oe_q    <= clk_oe_d;
      data_oe_q   <= data_oe_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
`ifdef PS2_TX_RETRY_EN
      retry_q     <= retry_d;
`endif
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed and random host-to-device frames against a PS/2 device model.
// Frames are checked bit-for-bit at the device's rising-edge samples.
module tb_ps2_host_tx;

  localparam int INH  = 20;
  localparam int TO   = 2000;
  localparam int FLT  = 2;
  localparam int HALF = 100;
`ifdef PS2_TX_RETRY_EN
  localparam int ATT_FAIL = 3;
`else
  localparam int ATT_FAIL = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] err_code;

  logic dev_clk_low;
  logic dev_data_low;

  int checks = 0;
  int failures = 0;

  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO),
    .FILTER_LEN(FLT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .ps2_clk_in(ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy(busy),
    .done(done),
    .err(err),
    .err_code(err_code)
  );

  // Reference: start 0, data LSB first, odd parity, stop 1 (index = bit order on the wire).
  function automatic logic [10:0] exp_frame(input logic [7:0] d);
    int ones;
    logic par;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    par = (ones % 2 == 0);
    return {1'b1, par, d, 1'b0};
  endfunction

  // Device model: mode 0 = ACK, 1 = NACK, 2 = silent.
  int dev_mode = 0;
  int dph = 0;
  int tick = 0;
  int pulse = 0;
  bit rx_q[$];

  initial begin
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        dph = 0;
      end else if (dph == 0) begin
        if (!ps2_clk_oe && !ps2_data_in && dev_mode != 2) begin
          dph = 1;
          tick = 0;
        end
      end else if (dph == 1) begin
        tick++;
        if (tick == 50) begin
          rx_q.push_back(ps2_data_in);
          dph = 2;
          tick = 0;
          pulse = 1;
        end
      end else begin
        if (tick == 0) dev_clk_low = 1'b1;
        if (tick == HALF) begin
          dev_clk_low = 1'b0;
          if (pulse <= 10) rx_q.push_back(ps2_data_in);
        end
        if (tick == HALF + 50 && pulse == 10 && dev_mode == 0) dev_data_low = 1'b1;
        if (tick == HALF + 50 && pulse == 11) dev_data_low = 1'b0;
        tick++;
        if (tick == 2 * HALF) begin
          tick = 0;
          if (pulse == 11) dph = 0;
          else pulse++;
        end
      end
    end
  end

  // Line monitor.
  int cyc = 0;
  int inh_phases = 0;
  int inh_only = 0;
  int overlap = 0;
  int req_cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  logic done_err = 1'b0;
  logic [1:0] done_code = 2'd0;
  logic prev_clk_oe = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (ps2_clk_oe && !prev_clk_oe) inh_phases++;
      if (ps2_clk_oe && !ps2_data_oe) inh_only++;
      if (ps2_clk_oe && ps2_data_oe) overlap++;
      if (!ps2_clk_oe && prev_clk_oe && ps2_data_oe) req_cyc = cyc;
      if (done === 1'b1) begin
        if (done_cnt == 0) begin
          done_cyc  = cyc;
          done_err  = err;
          done_code = err_code;
        end
        done_cnt++;
      end
      prev_clk_oe = ps2_clk_oe;
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    assert (got === expv) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, expv);
    end
  endtask

  task automatic clear_mon();
    rx_q.delete();
    inh_phases = 0;
    inh_only = 0;
    overlap = 0;
    done_cnt = 0;
    req_cyc = 0;
  endtask

  task automatic pulse_start(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 30000) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    chk({tag, "_done_count"}, done_cnt, 1);
    chk({tag, "_busy_end"}, busy, 1'b0);
  endtask

  function automatic logic [10:0] rx_vec();
    logic [10:0] v;
    v = '0;
    for (int i = 0; i < 11; i++) if (i < rx_q.size()) v[i] = rx_q[i];
    return v;
  endfunction

  task automatic run_tx(input string tag, input logic [7:0] d, input int mode);
    dev_mode = mode;
    clear_mon();
    pulse_start(d);
    wait_done(tag);
    repeat (300) @(negedge clk);
    if (mode != 2) chk({tag, "_frame"}, rx_vec(), exp_frame(d));
    chk({tag, "_err"}, done_err, (mode != 0));
    chk({tag, "_code"}, done_code, (mode == 0) ? 0 : (mode == 1) ? 1 : 2);
  endtask

  initial begin
    int n;
    logic [7:0] d;
    int m;

    rst = 1'b1;
    tx_start = 1'b1;
    tx_data = 8'hA5;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    tx_start = 1'b0;
    @(negedge clk);
    chk("rst_clk_oe", ps2_clk_oe, 1'b0);
    chk("rst_data_oe", ps2_data_oe, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_err_code", err_code, 2'd0);

    // 1: 0xED with ACK, inhibit shape.
    run_tx("t1", 8'hED, 0);
    chk("t1_frame_len", rx_q.size(), 11);
    chk("t1_inhibit_only", inh_only, INH);
    chk("t1_inhibit_overlap", overlap, 1);
    chk("t1_inhibit_phases", inh_phases, 1);

    // 2: 0xF4 with ACK.
    run_tx("t2", 8'hF4, 0);

    // 3: NACK on 0x01.
    run_tx("t3", 8'h01, 1);
    chk("t3_attempts", inh_phases, ATT_FAIL);
    chk("t3_frame_len", rx_q.size(), 11 * ATT_FAIL);

    // 4: silent device -> timeout.
    run_tx("t4", 8'hF4, 2);
    chk("t4_timeout_latency", done_cyc - req_cyc, TO);
    chk("t4_clk_oe", ps2_clk_oe, 1'b0);
    chk("t4_data_oe", ps2_data_oe, 1'b0);
    chk("t4_attempts", inh_phases, ATT_FAIL);

    // 5: second tx_start while busy is ignored.
    dev_mode = 0;
    clear_mon();
    pulse_start(8'hED);
    repeat (300) @(negedge clk);
    tx_data = 8'h55;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    wait_done("t5");
    repeat (300) @(negedge clk);
    chk("t5_frame", rx_vec(), exp_frame(8'hED));
    chk("t5_err", done_err, 1'b0);
    chk("t5_inhibit_phases", inh_phases, 1);
    chk("t5_done_total", done_cnt, 1);

    // 6: reset during data bit 4, then a clean frame.
    dev_mode = 0;
    clear_mon();
    pulse_start(8'hF4);
    n = 0;
    while (rx_q.size() < 5 && n < 10000) begin
      @(negedge clk);
      n++;
    end
    chk("t6_reached_bit4", (rx_q.size() >= 5), 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_clk_oe", ps2_clk_oe, 1'b0);
    chk("t6_rst_data_oe", ps2_data_oe, 1'b0);
    chk("t6_rst_busy", busy, 1'b0);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    chk("t6_no_done", done_cnt, 0);
    run_tx("t6b", 8'hF4, 0);

    // Random bytes with random ACK/NACK.
    for (int k = 0; k < 6; k++) begin
      d = 8'($urandom_range(0, 255));
      m = int'($urandom_range(0, 1));
      run_tx("rnd", d, m);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
